// File: rtl/display_arbiter.sv
// Two-requester arbiter for a 4-digit multiplexed display.
// Ownership changes only at frame boundaries, and the scan runs continuously.
module display_arbiter #(
  parameter int DIGIT_CYCLES = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int MIN_FRAMES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        an3,
  output logic        an2,
  output logic        an1,
  output logic        an0,
  output logic [3:0]  char,
  output logic        frame_done
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int HW = $clog2(MIN_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [HW-1:0] HELD_MAX = HW'(MIN_FRAMES);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    slot, slot_nxt;
  logic [HW-1:0] held, held_nxt;
  logic          last, last_nxt;
  logic [15:0]   latch, latch_nxt;
  logic          boundary;
  logic [3:0]    an_nxt;
  logic [3:0]    char_nxt;

  // Scan position for the next cycle; slot 0 is an3 and slot 3 is an0.
  always_comb begin
    boundary = (slot == 2'd3) && (cnt == CNT_LAST);
    if (cnt == CNT_LAST) begin
      cnt_nxt  = '0;
      slot_nxt = slot + 2'd1;
    end else begin
      cnt_nxt  = cnt + CW'(1);
      slot_nxt = slot;
    end
  end

  // Arbitration decision, applied only when the current cycle ends a frame.
  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    last_nxt  = last;
    latch_nxt = latch;
    if (boundary) begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last)) begin
            state_nxt = OWN0;
          end else if (req1) begin
            state_nxt = OWN1;
          end
        end
        OWN0: begin
          if (!req0) begin
            state_nxt = req1 ? OWN1 : IDLE;
          end else if (req1 && held == HELD_MAX) begin
            state_nxt = OWN1;
          end else if (held != HELD_MAX) begin
            held_nxt = held + HW'(1);
          end
        end
        OWN1: begin
          if (!req1) begin
            state_nxt = req0 ? OWN0 : IDLE;
          end else if (req0 && held == HELD_MAX) begin
            state_nxt = OWN0;
          end else if (held != HELD_MAX) begin
            held_nxt = held + HW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
      case (state_nxt)
        OWN0:    latch_nxt = data0;
        OWN1:    latch_nxt = data1;
        default: latch_nxt = '0;
      endcase
      if (state_nxt != state) begin
        case (state_nxt)
          OWN0: begin
            held_nxt = HW'(1);
            last_nxt = 1'b0;
          end
          OWN1: begin
            held_nxt = HW'(1);
            last_nxt = 1'b1;
          end
          default: held_nxt = '0;
        endcase
      end
    end
  end

  // Display outputs are derived from next-cycle values so that the registers line up with the scan.
  always_comb begin
    an_nxt   = 4'b1111;
    char_nxt = 4'h0;
    if (state_nxt != IDLE) begin
      case (slot_nxt)
        2'd0:    char_nxt = latch_nxt[15:12];
        2'd1:    char_nxt = latch_nxt[11:8];
        2'd2:    char_nxt = latch_nxt[7:4];
        default: char_nxt = latch_nxt[3:0];
      endcase
      if (int'(cnt_nxt) >= BLANK_CYCLES) begin
        an_nxt[2'd3 - slot_nxt] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      slot       <= 2'd0;
      state      <= IDLE;
      held       <= '0;
      last       <= 1'b1;
      latch      <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      {an3, an2, an1, an0} <= 4'b1111;
      char       <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      slot       <= slot_nxt;
      state      <= state_nxt;
      held       <= held_nxt;
      last       <= last_nxt;
      latch      <= latch_nxt;
      gnt0       <= (state_nxt == OWN0);
      gnt1       <= (state_nxt == OWN1);
      {an3, an2, an1, an0} <= an_nxt;
      char       <= char_nxt;
      frame_done <= (slot_nxt == 2'd3) && (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter using default parameters (64-cycle frame).
// Cycle k is the k-th cycle after reset release; sampling is done 1 ns after each rising edge.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] data0 = 16'h0, data1 = 16'h0;
  logic        gnt0, gnt1, an3, an2, an1, an0, frame_done;
  logic [3:0]  char;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  display_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .char(char), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  function automatic logic [31:0] an_v();
    return 32'({an3, an2, an1, an0});
  endfunction

  function automatic logic [31:0] gnt_v();
    return 32'({gnt1, gnt0});
  endfunction

  int bad;

  initial begin
    // Idle scan: no requests for 200 cycles.
    do_reset();
    check("rst_an", an_v(), 32'hF);
    check("rst_char", 32'(char), 32'h0);
    check("rst_gnt", gnt_v(), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    bad = 0;
    while (cyc < 199) begin
      tick();
      if (an_v() != 32'hF || char != 4'h0 || gnt_v() != 32'h0) bad++;
      if (frame_done != ((cyc % 64) == 63)) bad++;
      if (cyc == 63)  check("idle_fd63", 32'(frame_done), 32'h1);
      if (cyc == 64)  check("idle_fd64", 32'(frame_done), 32'h0);
      if (cyc == 127) check("idle_fd127", 32'(frame_done), 32'h1);
      if (cyc == 191) check("idle_fd191", 32'(frame_done), 32'h1);
    end
    check("idle_violations", 32'(bad), 32'h0);

    // Single owner, scan timing and latch behaviour.
    do_reset();
    req0 = 1'b1;
    data0 = 16'h1234;
    run_to(63);  check("own_gnt63", gnt_v(), 32'h0);
    run_to(64);  check("own_gnt64", gnt_v(), 32'h1);
                 check("own_an64", an_v(), 32'hF);
                 check("own_char64", 32'(char), 32'h1);
    run_to(65);  check("own_an65", an_v(), 32'hF);
    run_to(66);  check("own_an66", an_v(), 32'h7);
                 check("own_char66", 32'(char), 32'h1);
    run_to(79);  check("own_an79", an_v(), 32'h7);
    run_to(80);  check("own_an80", an_v(), 32'hF);
                 check("own_char80", 32'(char), 32'h2);
    run_to(81);  check("own_an81", an_v(), 32'hF);
    run_to(82);  check("own_an82", an_v(), 32'hB);
    run_to(98);  check("own_an98", an_v(), 32'hD);
                 check("own_char98", 32'(char), 32'h3);
    run_to(100); data0 = 16'hABCD;
    run_to(114); check("own_an114", an_v(), 32'hE);
                 check("own_char114_old", 32'(char), 32'h4);
    run_to(128); check("new_char128", 32'(char), 32'hA);
    run_to(146); check("new_char146", 32'(char), 32'hB);
                 check("new_an146", an_v(), 32'hB);
    run_to(162); check("new_char162", 32'(char), 32'hC);
    run_to(178); check("new_char178", 32'(char), 32'hD);
                 check("new_an178", an_v(), 32'hE);
    run_to(180); req0 = 1'b0;
    run_to(192); check("rel_gnt192", gnt_v(), 32'h0);
                 check("rel_char192", 32'(char), 32'h0);
    // Last owner was 0, so a simultaneous request goes to requester 1.
    run_to(200); req0 = 1'b1; req1 = 1'b1; data1 = 16'h5678;
    run_to(256); check("tie_gnt256", gnt_v(), 32'h2);
    run_to(258); check("tie_char258", 32'(char), 32'h5);

    // Both requesters held from reset: ownership alternates every 2 frames.
    req0 = 1'b1; req1 = 1'b1;
    do_reset();
    run_to(63);  check("alt_gnt63", gnt_v(), 32'h0);
    run_to(70);  check("alt_gnt_f1", gnt_v(), 32'h1);
    run_to(134); check("alt_gnt_f2", gnt_v(), 32'h1);
    run_to(198); check("alt_gnt_f3", gnt_v(), 32'h2);
    run_to(262); check("alt_gnt_f4", gnt_v(), 32'h2);
    run_to(326); check("alt_gnt_f5", gnt_v(), 32'h1);
    run_to(390); check("alt_gnt_f6", gnt_v(), 32'h1);
    run_to(454); check("alt_gnt_f7", gnt_v(), 32'h2);
    // Owner 1 drops its request mid-frame while requester 0 is also idle.
    run_to(460); req0 = 1'b0; req1 = 1'b0;
    run_to(511); check("drop_gnt511", gnt_v(), 32'h2);
                 check("drop_fd511", 32'(frame_done), 32'h1);
    run_to(512); check("drop_gnt512", gnt_v(), 32'h0);
    run_to(514); check("drop_an514", an_v(), 32'hF);
                 check("drop_char514", 32'(char), 32'h0);
    // A request pulse between boundaries is ignored.
    run_to(520); req0 = 1'b1;
    tick();      req0 = 1'b0;
    run_to(576); check("pulse_gnt576", gnt_v(), 32'h0);

    // Reset pulse mid-slot while owned by requester 0.
    do_reset();
    req0 = 1'b1; data0 = 16'h1234;
    run_to(70);  check("mid_gnt70", gnt_v(), 32'h1);
                 check("mid_an70", an_v(), 32'h7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    check("mid_rst_gnt", gnt_v(), 32'h0);
    check("mid_rst_an", an_v(), 32'hF);
    check("mid_rst_char", 32'(char), 32'h0);
    check("mid_rst_fd", 32'(frame_done), 32'h0);
    run_to(63);  check("mid_fd63", 32'(frame_done), 32'h1);
                 check("mid_gnt63", gnt_v(), 32'h0);
    run_to(64);  check("mid_gnt64", gnt_v(), 32'h1);
    run_to(66);  check("mid_an66", an_v(), 32'h7);
                 check("mid_char66", 32'(char), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 16: clock cycles per digit slot, blank time included; legal range 2 or more.
REQ-002 SHALL have parameter BLANK_CYCLES, default 2: anode-off cycles at the start of each slot; legal range 0 to DIGIT_CYCLES-1.
REQ-003 SHALL have parameter MIN_FRAMES, default 2: full frames an owner holds before it can be preempted; legal range 1 or more.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports req0 and req1, input, 1 bit each: display-ownership request from requester 0 and requester 1.
REQ-007 SHALL have ports data0 and data1, input, 16 bits each: four hex nibbles per requester; [15:12] is the leftmost digit.
REQ-008 SHALL have ports gnt0 and gnt1, output, 1 bit each, registered: at most one is high.
REQ-009 SHALL have ports an3, an2, an1, an0, output, 1 bit each, registered, active-low digit enables.
REQ-010 SHALL have port char, output, 4 bits, registered: nibble for the currently scanned digit, fed to the LED decoder.
REQ-011 SHALL have port frame_done, output, 1 bit, registered: one-cycle pulse marking a frame boundary.

Function
REQ-012 SHALL run a free-running scan: cycle counter 0 to DIGIT_CYCLES-1 within each slot; slot order an3, an2, an1, an0, then wrap to an3.
REQ-013 SHALL define the frame boundary as the cycle where slot = an0 and counter = DIGIT_CYCLES-1; frame length SHALL be 4*DIGIT_CYCLES cycles (64 by default).
REQ-014 SHALL, within a slot, drive all anodes high for counter < BLANK_CYCLES, otherwise drive only that slot's anode low.
REQ-015 SHALL drive char from the frame latch during the whole slot: an3 uses [15:12], an2 [11:8], an1 [7:4], an0 [3:0].
REQ-016 SHALL evaluate arbitration only on the frame-boundary cycle; new gnt, state and frame latch SHALL take effect on the first cycle of the next frame.
REQ-017 SHALL, at that same edge, load the frame latch from the new owner's data; data changes mid-frame SHALL NOT alter char.
REQ-018 SHALL implement the arbiter states IDLE, OWN0 and OWN1, and SHALL count held frames per owner, saturating at MIN_FRAMES.
REQ-019 IDLE at boundary: req0 only goes to OWN0; req1 only goes to OWN1; neither keeps IDLE.
REQ-020 IDLE at boundary with both requesting: the grant SHALL go to the requester that was not the last owner; after reset requester 0 wins.
REQ-021 OWNx at boundary with reqx low SHALL release: go to the other owner state if the other requests, else to IDLE.
REQ-022 OWNx at boundary with reqx high, the other requesting and held count = MIN_FRAMES SHALL switch to the other owner.
REQ-023 Any other OWNx boundary case SHALL stay in OWNx and increment the held count.
REQ-024 Any entry into an owner state SHALL set the held count to 1.
REQ-025 SHALL, in IDLE, hold all anodes high and char = 0 while the scan counters keep running.
REQ-026 SHALL pulse frame_done high exactly on each boundary cycle, in every state.
REQ-027 Request changes between boundaries SHALL have no effect; a request pulse that misses the boundary SHALL be ignored.

Reset
REQ-028 SHALL, when reset is high at a clock edge, set counter = 0, slot = an3, state = IDLE, gnt0 = gnt1 = 0, anodes = 1111, char = 0, frame_done = 0, latch = 0, held count = 0, and last owner = 1 (so requester 0 wins first).
REQ-029 Reset SHALL take priority over all other activity, including mid-frame; the first post-reset frame boundary SHALL occur 64 cycles after reset is released (defaults).

Verification
REQ-030 Reset release, no requests, 200 cycles -> anodes stay 1111, char = 0, gnt = 00, frame_done pulses at cycles 63, 127 and 191.
REQ-031 req0 = 1 with data0 = 0x1234 -> gnt0 rises at cycle 64; an3 low from cycle 66 to 79 with char = 1; an0 slot shows char = 4; blank on cycles 64, 65, 80, 81.
REQ-032 OWN0 with data0 changed to 0xABCD mid-frame -> char keeps the old nibbles until the next frame, then shows A, B, C, D.
REQ-033 req0 and req1 both held high from reset -> OWN0 for frames 1-2, OWN1 for frames 3-4, OWN0 again, alternating every 2 frames.
REQ-034 OWN1 active, req1 dropped mid-frame, req0 = 0 -> state goes to IDLE at the next boundary, gnt1 falls, anodes go to 1111.
REQ-035 reset asserted for 1 cycle mid-slot while in OWN0 -> next cycle shows all reset values; the scan restarts at an3 with counter 0.
